// File: rtl/cdb_arbiter_if.sv
// Common data bus request/broadcast bundle between functional units and the CDB arbiter.
// The master side is the FU cluster plus CDB consumers; the slave side is the arbiter.
interface cdb_arbiter_if #(
   parameter int unsigned NUM_FU    = 6,
   parameter int unsigned WAYS      = 2,
   parameter int unsigned ROB_IDX_W = 5,
   parameter int unsigned PRF_IDX_W = 6,
   parameter int unsigned XLEN      = 32
);

   logic [NUM_FU-1:0]                req_valid;
   logic [NUM_FU-1:0][ROB_IDX_W-1:0] req_rob_idx;
   logic [NUM_FU-1:0][PRF_IDX_W-1:0] req_prn;
   logic [NUM_FU-1:0][XLEN-1:0]      req_value;
   logic [NUM_FU-1:0]                req_direction;
   logic [NUM_FU-1:0][XLEN-1:0]      req_target;
   logic [NUM_FU-1:0]                req_ready;

   logic [WAYS-1:0]                  CDB_valid;
   logic [WAYS-1:0][ROB_IDX_W-1:0]   CDB_ROB_idx;
   logic [WAYS-1:0][PRF_IDX_W-1:0]   CDB_PRN;
   logic [WAYS-1:0][XLEN-1:0]        CDB_value;
   logic [WAYS-1:0]                  CDB_direction;
   logic [WAYS-1:0][XLEN-1:0]        CDB_target;

   modport master (
      output req_valid, req_rob_idx, req_prn, req_value, req_direction, req_target,
      input  req_ready,
      input  CDB_valid, CDB_ROB_idx, CDB_PRN, CDB_value, CDB_direction, CDB_target
   );

   modport slave (
      input  req_valid, req_rob_idx, req_prn, req_value, req_direction, req_target,
      output req_ready,
      output CDB_valid, CDB_ROB_idx, CDB_PRN, CDB_value, CDB_direction, CDB_target
   );

endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to WAYS functional-unit completions per cycle onto a
// registered common data bus; a nuke squashes all grants and the next broadcast.
module cdb_arbiter #(
   parameter int unsigned NUM_FU    = 6,
   parameter int unsigned WAYS      = 2,
   parameter int unsigned ROB_IDX_W = 5,
   parameter int unsigned PRF_IDX_W = 6,
   parameter int unsigned XLEN      = 32,
   localparam int unsigned PtrW     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              nuke,
   cdb_arbiter_if.slave      bus,
   output logic [PtrW-1:0]   rr_ptr
);

   localparam int unsigned CntW = $clog2(WAYS + 1);

   logic [PtrW-1:0]                rr_ptr_q, rr_ptr_d;
   logic [NUM_FU-1:0]              valid_eff;
   logic [NUM_FU-1:0]              grant;
   logic [WAYS-1:0]                slot_used;
   logic [WAYS-1:0][PtrW-1:0]      slot_sel;
   logic [PtrW-1:0]                last_fu;
   logic                           any_grant;
   logic [PtrW:0]                  scan;
   logic [PtrW-1:0]                idx;
   logic [CntW-1:0]                cnt;

   logic [WAYS-1:0]                cdb_valid_q;
   logic [WAYS-1:0][ROB_IDX_W-1:0] cdb_rob_idx_q;
   logic [WAYS-1:0][PRF_IDX_W-1:0] cdb_prn_q;
   logic [WAYS-1:0][XLEN-1:0]      cdb_value_q;
   logic [WAYS-1:0]                cdb_direction_q;
   logic [WAYS-1:0][XLEN-1:0]      cdb_target_q;

   // A nuke hides every request, so no grant, no pointer move and an empty broadcast follow.
   assign valid_eff = nuke ? '0 : bus.req_valid;

   // Scan from rr_ptr with a modulo-NUM_FU wrap; the k-th hit lands in slot k.
   always_comb begin
      grant     = '0;
      slot_used = '0;
      slot_sel  = '0;
      last_fu   = rr_ptr_q;
      any_grant = 1'b0;
      cnt       = '0;
      scan      = '0;
      idx       = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         scan = {1'b0, rr_ptr_q} + (PtrW + 1)'(i);
         if (scan >= (PtrW + 1)'(NUM_FU)) begin
            scan = scan - (PtrW + 1)'(NUM_FU);
         end
         idx = scan[PtrW-1:0];
         if (valid_eff[idx] && (cnt < CntW'(WAYS))) begin
            grant[idx] = 1'b1;
            for (int unsigned s = 0; s < WAYS; s++) begin
               if (cnt == CntW'(s)) begin
                  slot_used[s] = 1'b1;
                  slot_sel[s]  = idx;
               end
            end
            cnt       = cnt + CntW'(1);
            last_fu   = idx;
            any_grant = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (any_grant) begin
         rr_ptr_d = (last_fu == PtrW'(NUM_FU - 1)) ? '0 : last_fu + PtrW'(1);
      end
   end

   // Ready is forced low for as long as the asynchronous reset is held.
   assign bus.req_ready = reset ? grant : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr_q        <= '0;
         cdb_valid_q     <= '0;
         cdb_rob_idx_q   <= '0;
         cdb_prn_q       <= '0;
         cdb_value_q     <= '0;
         cdb_direction_q <= '0;
         cdb_target_q    <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= slot_used;
         for (int unsigned s = 0; s < WAYS; s++) begin
            if (slot_used[s]) begin
               cdb_rob_idx_q[s]   <= bus.req_rob_idx[slot_sel[s]];
               cdb_prn_q[s]       <= bus.req_prn[slot_sel[s]];
               cdb_value_q[s]     <= bus.req_value[slot_sel[s]];
               cdb_direction_q[s] <= bus.req_direction[slot_sel[s]];
               cdb_target_q[s]    <= bus.req_target[slot_sel[s]];
            end
         end
      end
   end

   assign rr_ptr            = rr_ptr_q;
   assign bus.CDB_valid     = cdb_valid_q;
   assign bus.CDB_ROB_idx   = cdb_rob_idx_q;
   assign bus.CDB_PRN       = cdb_prn_q;
   assign bus.CDB_value     = cdb_value_q;
   assign bus.CDB_direction = cdb_direction_q;
   assign bus.CDB_target    = cdb_target_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed grant vectors plus a hold-until-granted random phase,
// with expected broadcasts queued by the driver and checked by an independent monitor.
module tb_cdb_arbiter;

   localparam int unsigned NUM_FU    = 6;
   localparam int unsigned WAYS      = 2;
   localparam int unsigned ROB_IDX_W = 5;
   localparam int unsigned PRF_IDX_W = 6;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned PW        = 3;
   localparam int unsigned PAY_W     = ROB_IDX_W + PRF_IDX_W + XLEN + 1 + XLEN;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          nuke  = 1'b0;
   logic [PW-1:0] rr_ptr;

   cdb_arbiter_if #(
      .NUM_FU(NUM_FU), .WAYS(WAYS), .ROB_IDX_W(ROB_IDX_W), .PRF_IDX_W(PRF_IDX_W), .XLEN(XLEN)
   ) bus ();

   cdb_arbiter #(
      .NUM_FU(NUM_FU), .WAYS(WAYS), .ROB_IDX_W(ROB_IDX_W), .PRF_IDX_W(PRF_IDX_W), .XLEN(XLEN)
   ) dut (
      .clock (clock),
      .reset (reset),
      .nuke  (nuke),
      .bus   (bus.slave),
      .rr_ptr(rr_ptr)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [1:0]                  n;
      logic                        ordered;
      logic                        chk_ptr;
      logic [PW-1:0]               ptr;
      logic [1:0][PAY_W-1:0]       pay;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [PAY_W-1:0] fu_pay(input int i);
      return {bus.req_rob_idx[i], bus.req_prn[i], bus.req_value[i], bus.req_direction[i],
              bus.req_target[i]};
   endfunction

   function automatic logic [PAY_W-1:0] cdb_pay(input int s);
      return {bus.CDB_ROB_idx[s], bus.CDB_PRN[s], bus.CDB_value[s], bus.CDB_direction[s],
              bus.CDB_target[s]};
   endfunction

   // One directed cycle: hand-computed ready vector, slot owners (-1 = empty) and next rr_ptr.
   task automatic step(input logic [5:0] valid, input logic nk, input logic [5:0] exp_ready,
                       input int s0, input int s1, input logic [PW-1:0] exp_ptr,
                       input string name);
      exp_t e;
      @(negedge clock);
      bus.req_valid = valid;
      nuke          = nk;
      #2;
      check($sformatf("%s.ready", name), 128'(bus.req_ready), 128'(exp_ready));
      e         = '0;
      e.ordered = 1'b1;
      e.chk_ptr = 1'b1;
      e.ptr     = exp_ptr;
      if (s0 >= 0) begin
         e.n      = 2'd1;
         e.pay[0] = fu_pay(s0);
      end
      if (s1 >= 0) begin
         e.n      = 2'd2;
         e.pay[1] = fu_pay(s1);
      end
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [1:0] mask;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e    = sb.pop_front();
            mask = (e.n == 2'd0) ? 2'b00 : (e.n == 2'd1) ? 2'b01 : 2'b11;
            check("cdb_valid", 128'(bus.CDB_valid), 128'(mask));
            if (e.chk_ptr) check("rr_ptr", 128'(rr_ptr), 128'(e.ptr));
            if (e.ordered || e.n < 2'd2) begin
               for (int s = 0; s < int'(e.n); s++) begin
                  check($sformatf("cdb_slot%0d", s), 128'(cdb_pay(s)), 128'(e.pay[s]));
               end
            end else begin
               checks++;
               if (!(((cdb_pay(0) == e.pay[0]) && (cdb_pay(1) == e.pay[1])) ||
                     ((cdb_pay(0) == e.pay[1]) && (cdb_pay(1) == e.pay[0])))) begin
                  errors++;
                  $display("FAIL cdb_pair: got %0h/%0h expected %0h/%0h", cdb_pay(0),
                           cdb_pay(1), e.pay[0], e.pay[1]);
               end
            end
         end
      end
   end

   initial begin : driver
      logic [5:0]           all;
      logic [5:0]           granted;
      logic [ROB_IDX_W-1:0] next_rob;
      logic                 nk;
      int                   age[NUM_FU];
      int                   exp_n;
      exp_t                 e;

      all = '1;
      for (int i = 0; i < int'(NUM_FU); i++) begin
         bus.req_rob_idx[i]   = ROB_IDX_W'(10 + i);
         bus.req_prn[i]       = PRF_IDX_W'(20 + i);
         bus.req_value[i]     = 32'hA000_0000 + 32'(i);
         bus.req_direction[i] = 1'(i);
         bus.req_target[i]    = 32'h0000_1000 + 32'(4 * i);
         age[i]               = 0;
      end
      bus.req_valid = all;

      repeat (2) @(posedge clock);
      #1;
      check("reset.rr_ptr", 128'(rr_ptr), 128'(0));
      check("reset.cdb_valid", 128'(bus.CDB_valid), 128'(0));
      check("reset.cdb_value", 128'(bus.CDB_value), 128'(0));
      check("reset.ready", 128'(bus.req_ready), 128'(0));
      #2;
      reset = 1'b1;

      bus.req_rob_idx[0] = 5'd3;
      bus.req_prn[0]     = 6'd9;
      bus.req_value[0]   = 32'hDEAD_BEEF;
      step(6'b000001, 1'b0, 6'b000001, 0, -1, 3'd1, "single");
      step(6'b000000, 1'b0, 6'b000000, -1, -1, 3'd1, "idle");
      step(6'b100000, 1'b0, 6'b100000, 5, -1, 3'd0, "fu5_alone");
      step(all, 1'b0, 6'b000011, 0, 1, 3'd2, "all_a");
      step(all, 1'b0, 6'b001100, 2, 3, 3'd4, "all_b");
      step(all, 1'b0, 6'b110000, 4, 5, 3'd0, "all_c");
      step(all, 1'b0, 6'b000011, 0, 1, 3'd2, "all_d");
      step(6'b010000, 1'b0, 6'b010000, 4, -1, 3'd5, "fu4_alone");
      step(6'b100001, 1'b0, 6'b100001, 5, 0, 3'd1, "wrap");
      step(6'b010110, 1'b1, 6'b000000, -1, -1, 3'd1, "nuke");
      step(6'b010110, 1'b0, 6'b000110, 1, 2, 3'd3, "after_nuke");
      step(6'b010000, 1'b0, 6'b010000, 4, -1, 3'd5, "leftover");
      step(6'b001000, 1'b0, 6'b001000, 3, -1, 3'd4, "behind_ptr");
      step(all, 1'b0, 6'b110000, 4, 5, 3'd0, "all_e");
      step(all, 1'b0, 6'b000011, 0, 1, 3'd2, "all_f");

      // Assert reset mid-cycle while both slots are valid, then hold it across an edge.
      @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check("async.cdb_valid", 128'(bus.CDB_valid), 128'(0));
      check("async.rr_ptr", 128'(rr_ptr), 128'(0));
      check("async.ready", 128'(bus.req_ready), 128'(0));
      @(posedge clock);
      #1;
      check("held.rr_ptr", 128'(rr_ptr), 128'(0));
      check("held.ready", 128'(bus.req_ready), 128'(0));
      #2;
      reset = 1'b1;
      step(all, 1'b0, 6'b000011, 0, 1, 3'd2, "after_reset");
      step(6'b000000, 1'b0, 6'b000000, -1, -1, 3'd2, "quiet");

      granted  = '0;
      next_rob = '0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clock);
         for (int i = 0; i < int'(NUM_FU); i++) begin
            if (!bus.req_valid[i] || granted[i]) begin
               if ($urandom_range(1, 0) == 1) begin
                  bus.req_valid[i]     = 1'b1;
                  bus.req_rob_idx[i]   = next_rob;
                  next_rob             = next_rob + ROB_IDX_W'(1);
                  bus.req_prn[i]       = PRF_IDX_W'($urandom);
                  bus.req_value[i]     = $urandom;
                  bus.req_direction[i] = 1'($urandom);
                  bus.req_target[i]    = $urandom;
                  age[i]               = 0;
               end else begin
                  bus.req_valid[i] = 1'b0;
               end
            end
         end
         nk   = ($urandom_range(15, 0) == 0);
         nuke = nk;
         #2;
         granted = bus.req_ready;
         exp_n   = nk ? 0 : (($countones(bus.req_valid) > 2) ? 2 : $countones(bus.req_valid));
         check("rand.grants", {96'(granted & ~bus.req_valid), 32'($countones(granted))},
               {96'(0), 32'(exp_n)});
         e = '0;
         for (int i = 0; i < int'(NUM_FU); i++) begin
            if (bus.req_valid[i]) begin
               if (!nk) age[i]++;
               if (granted[i]) begin
                  check($sformatf("rand.wait_fu%0d", i), 128'(age[i] <= 3), 128'(1));
                  if (e.n < 2'd2) begin
                     e.pay[e.n] = fu_pay(i);
                     e.n        = e.n + 2'd1;
                  end
               end
            end
         end
         sb.push_back(e);
      end

      @(negedge clock);
      bus.req_valid = '0;
      nuke          = 1'b0;
      #2;
      sb.push_back('0);
      repeat (3) @(posedge clock);
      #2;
      check("scoreboard_drained", 128'(sb.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the WAYS-wide common data bus among NUM_FU functional-unit completion requesters using rotating round-robin priority.
- Each cycle, grants up to WAYS requests and registers them onto the CDB, one cycle later.
- Drives the reorder buffer's CDB_valid/CDB_ROB_idx/CDB_direction/CDB_target inputs and the reservation-station/PRF wakeup bus.
- Squashes all traffic on a processor nuke.

Parameters:
NUM_FU, 6, number of requesting functional units (>= WAYS)
WAYS, 2, CDB broadcast slots per cycle
ROB_IDX_W, 5, ROB index width (clog2 of ROB depth 32)
PRF_IDX_W, 6, physical register index width
XLEN, 32, data/target width

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
nuke  in  1  processor flush (ROB proc_nuke), active high
req_valid  in  NUM_FU  FU has a completed result
req_rob_idx  in  NUM_FU x ROB_IDX_W  ROB entry of result
req_prn  in  NUM_FU x PRF_IDX_W  destination physical register
req_value  in  NUM_FU x XLEN  result data
req_direction  in  NUM_FU  resolved branch direction
req_target  in  NUM_FU x XLEN  resolved branch target
req_ready  out  NUM_FU  grant; FU may drop/advance its request this cycle
CDB_valid  out  WAYS  slot carries a result
CDB_ROB_idx  out  WAYS x ROB_IDX_W
CDB_PRN  out  WAYS x PRF_IDX_W
CDB_value  out  WAYS x XLEN
CDB_direction  out  WAYS
CDB_target  out  WAYS x XLEN
rr_ptr  out  clog2(NUM_FU)  current highest-priority FU (debug/verification)

Behaviour:
- State: rr_ptr register plus a WAYS-slot CDB output register. No other state.
- Reset (reset=0, async): rr_ptr=0. All CDB_* outputs = 0. req_ready = 0 (combinationally forced while reset asserted).
- Grant (combinational, same cycle):
  - Scan FUs in order rr_ptr, rr_ptr+1, ..., wrapping mod NUM_FU.
  - The first WAYS FUs found with req_valid=1 get req_ready=1; all other FUs get req_ready=0.
  - The k-th granted FU in scan order maps to slot k (slot 0 = highest priority). Unused slots are invalid.
- Handshake:
  - A transfer occurs when req_valid & req_ready in the same cycle.
  - The FU holds its request (valid and payload stable) until granted; the arbiter never drops a held request.
  - req_ready never depends on the FU's own payload fields.
- Latency: a granted request appears on CDB slot k at the next rising edge with CDB_valid[k]=1 and its fields copied unchanged. CDB outputs hold for exactly one cycle, then are overwritten by the next cycle's grants (invalid if none).
- Pointer update at the edge:
  - If at least one grant: rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
  - If no grant: rr_ptr unchanged.
- Fairness: any continuously asserted request is granted within ceil(NUM_FU/WAYS) cycles.
- Nuke:
  - While nuke=1: req_ready=0 for all FUs (no transfer) and rr_ptr unchanged.
  - At that edge, all CDB_valid <= 0; payload registers may hold stale values but are qualified by CDB_valid.
  - An entry already on the CDB during the nuke cycle is still visible that cycle; the ROB ignores it because it resets the same edge.
- Fewer requesters than WAYS: only the lowest slots are filled, contiguously from slot 0, with no holes.
- All requesters idle: CDB_valid=0 next cycle; rr_ptr unchanged.
- Wrap-around:
  - The scan crossing FU NUM_FU-1 -> 0 is treated identically to any other step.
  - rr_ptr arithmetic wraps modulo NUM_FU; it is not a power-of-two wrap when NUM_FU isn't a power of two.
- Reset mid-operation: asynchronous clear of rr_ptr and CDB registers regardless of nuke/requests. The first grant after release starts from FU 0.

Test Plan:
- Reset, then req_valid=6'b000001 with rob_idx=3, prn=9, value=0xDEADBEEF -> ready[0]=1 same cycle; next cycle CDB_valid=2'b01, CDB_ROB_idx[0]=3, CDB_PRN[0]=9, CDB_value[0]=0xDEADBEEF; rr_ptr=1.
- All 6 FUs request continuously from rr_ptr=0 -> grants {0,1}, {2,3}, {4,5}, {0,1} on successive cycles; rr_ptr sequence 2, 4, 0, 2.
- rr_ptr=5 with req_valid=6'b100001 -> FU5 in slot 0 and FU0 in slot 1 next cycle; rr_ptr=1.
- Three requests (FUs 1, 2, 4) with nuke=1 in the same cycle -> req_ready=0; next cycle CDB_valid=0; rr_ptr unchanged. Deassert nuke -> FUs 1 and 2 granted first.
- reset driven 0 asynchronously mid-cycle while CDB_valid=2'b11 -> CDB_valid=0 and rr_ptr=0 immediately, without waiting for a clock edge; req_ready=0 until release.
- Random requesters with hold-until-granted over 10k cycles -> no request waits more than 3 cycles, no duplicate/lost ROB indices, and CDB payloads match the granted requests.
